// File: rtl/alu_seq_if.sv
// Command/result bundle for alu_seq_unit: command handshake, result handshake,
// global enable and status flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             overflow;
  logic             illegal;
  logic             busy;

  modport master (
    output en, in_valid, opcode, a, b, res_ready,
    input  in_ready, res_valid, out, cout, overflow, illegal, busy
  );

  modport slave (
    input  en, in_valid, opcode, a, b, res_ready,
    output in_ready, res_valid, out, cout, overflow, illegal, busy
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops plus a shift-add
// multiplier that retires one multiplier bit per enabled clock.
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst_n,
  alu_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1110;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [WIDTH-1:0]   out_reg;
  logic               cout_reg;
  logic               ovf_reg;
  logic               ill_reg;

  logic               accept;
  logic               is_sub;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   op_out;
  logic               op_cout;
  logic               op_ovf;
  logic               op_ill;
  logic [2*WIDTH-1:0] acc_next;

  assign bus.in_ready  = (state_reg == IDLE) && bus.en;
  assign bus.res_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.out       = out_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = ovf_reg;
  assign bus.illegal   = ill_reg;

  assign accept = bus.in_ready && bus.in_valid;

  // Subtraction is a + ~b + 1, so add and sub share one adder.
  assign is_sub = (bus.opcode == OP_SUB);
  assign b_eff  = is_sub ? ~bus.b : bus.b;
  assign sum    = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    op_out  = '0;
    op_cout = 1'b0;
    op_ovf  = 1'b0;
    op_ill  = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_SUB: begin
        op_out  = sum[WIDTH-1:0];
        op_cout = sum[WIDTH];
        op_ovf  = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_OR:  op_out = bus.a | bus.b;
      OP_AND: op_out = bus.a & bus.b;
      OP_NOT: op_out = ~bus.a;
      OP_XOR: op_out = bus.a ^ bus.b;
      OP_SHL: op_out = bus.a << bus.b[CW-1:0];
      OP_SHR: op_out = bus.a >> bus.b[CW-1:0];
      OP_MUL: op_out = '0;
      default: op_ill = 1'b1;
    endcase
  end

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      out_reg    <= '0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      ill_reg    <= 1'b0;
    end else if (bus.en) begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (bus.opcode == OP_MUL) begin
              state_reg  <= EXEC;
              cnt_reg    <= '0;
              acc_reg    <= '0;
              mcand_reg  <= {{WIDTH{1'b0}}, bus.a};
              mplier_reg <= bus.b;
            end else begin
              state_reg <= DONE;
              out_reg   <= op_out;
              cout_reg  <= op_cout;
              ovf_reg   <= op_ovf;
              ill_reg   <= op_ill;
            end
          end
        end
        EXEC: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_STEP) begin
            state_reg <= DONE;
            out_reg   <= acc_next[WIDTH-1:0];
            cout_reg  <= 1'b0;
            ovf_reg   <= |acc_next[2*WIDTH-1:WIDTH];
            ill_reg   <= 1'b0;
          end
        end
        DONE: begin
          if (bus.res_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: transaction-level reference model checked
// every cycle, plus literal expectations for each directed vector.
module tb_alu_seq_unit;
  localparam int W = 32;

  localparam logic [3:0] OP_ADD = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1110;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_on = 1'b0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;
    logic         ill;
    logic         is_mul;
  } res_t;

  // Reference result straight from the arithmetic definitions.
  function automatic res_t model_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    res_t         r;
    longint       sa, sb, sr;
    logic [W:0]   u;
    logic [63:0]  p;
    r = '0;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (op)
      OP_ADD: begin
        u = {1'b0, av} + {1'b0, bv};
        sr = sa + sb;
        r.out = u[W-1:0];
        r.cout = u[W];
        r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_SUB: begin
        sr = sa - sb;
        r.out = av - bv;
        r.cout = (av >= bv);
        r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      OP_OR:  r.out = av | bv;
      OP_AND: r.out = av & bv;
      OP_NOT: r.out = ~av;
      OP_XOR: r.out = av ^ bv;
      OP_SHL: r.out = av << bv[4:0];
      OP_SHR: r.out = av >> bv[4:0];
      OP_MUL: begin
        p = 64'(av) * 64'(bv);
        r.out = p[W-1:0];
        r.ovf = (p[63:32] != 32'd0);
        r.is_mul = 1'b1;
      end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a result becomes visible after a number of
  // enabled edges (1 for single-cycle ops, 33 for mul, counting the accept edge).
  bit   m_valid = 1'b0;
  int   m_wait = 0;
  res_t m_res = '0;
  res_t m_pend = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_valid = 1'b0;
        m_wait  = 0;
        m_res   = '0;
      end else if (bus.en) begin
        if (m_valid) begin
          if (bus.res_ready) m_valid = 1'b0;
        end else if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) begin
            m_valid = 1'b1;
            m_res   = m_pend;
          end
        end else if (bus.in_valid) begin
          m_pend = model_op(bus.opcode, bus.a, bus.b);
          if (m_pend.is_mul) m_wait = 32;
          else begin
            m_valid = 1'b1;
            m_res   = m_pend;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cmp_res_valid", 64'(bus.res_valid), 64'(m_valid));
      chk("cmp_busy", 64'(bus.busy), 64'(m_valid || (m_wait > 0)));
      chk("cmp_in_ready", 64'(bus.in_ready), 64'(bus.en && !m_valid && (m_wait == 0)));
      if (m_valid) begin
        chk("cmp_out", 64'(bus.out), 64'(m_res.out));
        chk("cmp_cout", 64'(bus.cout), 64'(m_res.cout));
        chk("cmp_overflow", 64'(bus.overflow), 64'(m_res.ovf));
        chk("cmp_illegal", 64'(bus.illegal), 64'(m_res.ill));
      end
    end
  end

  // Issue one command and check the literal result; lat counts edges from
  // the accepting edge (inclusive) until res_valid is seen.
  task automatic do_op(input string nm, input logic [3:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] eo, input bit ec,
                       input bit ev, input bit ei, input int elat, input int hold,
                       input int stall_at, input int stall_len);
    int n;
    bus.opcode = op;
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'hFFFF_FFFF;
    n = 1;
    while (!bus.res_valid && n < 200) begin
      if (n == stall_at) begin
        bus.en = 1'b0;
        repeat (stall_len) begin
          @(posedge clk);
          #1;
          n++;
        end
        bus.en = 1'b1;
        if (bus.res_valid) break;
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(elat));
    chk({nm, "_out"}, 64'(bus.out), 64'(eo));
    chk({nm, "_cout"}, 64'(bus.cout), 64'(ec));
    chk({nm, "_overflow"}, 64'(bus.overflow), 64'(ev));
    chk({nm, "_illegal"}, 64'(bus.illegal), 64'(ei));
    repeat (hold) @(posedge clk);
    #1;
    chk({nm, "_held_out"}, 64'(bus.out), 64'(eo));
    chk({nm, "_held_valid"}, 64'(bus.res_valid), 64'd1);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk({nm, "_drop_valid"}, 64'(bus.res_valid), 64'd0);
    $display("txn %s op=%b a=%h b=%h -> out=%h cout=%b ovf=%b ill=%b lat=%0d",
             nm, op, av, bv, eo, ec, ev, ei, n);
  endtask

  initial begin
    int seen;
    bus.en = 1'b1;
    bus.in_valid = 1'b0;
    bus.opcode = 4'd0;
    bus.a = '0;
    bus.b = '0;
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 64'(bus.out), 64'd0);
    chk("reset_res_valid", 64'(bus.res_valid), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_flags", 64'({bus.cout, bus.overflow, bus.illegal}), 64'd0);
    rst_n = 1'b1;

    do_op("add_ff",   OP_ADD, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_01FE, 0, 0, 0, 1, 0, 0, 0);
    do_op("sub_0_1",  OP_SUB, 32'h0,         32'h1,         32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0);
    do_op("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 1, 0, 1, 0, 0, 0);
    do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0, 0, 1, 0, 0, 0);
    do_op("sub_5_3",  OP_SUB, 32'h5,         32'h3,         32'h2,         1, 0, 0, 1, 0, 0, 0);
    do_op("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1, 1, 0, 1, 0, 0, 0);
    do_op("or",       OP_OR,  32'hCC,        32'h33,        32'hFF,        0, 0, 0, 1, 0, 0, 0);
    do_op("and",      OP_AND, 32'hCC,        32'h33,        32'h0,         0, 0, 0, 1, 0, 0, 0);
    do_op("not",      OP_NOT, 32'hAA,        32'h1234,      32'hFFFF_FF55, 0, 0, 0, 1, 0, 0, 0);
    do_op("xor",      OP_XOR, 32'hF0F0,      32'h0FF0,      32'hFF00,      0, 0, 0, 1, 0, 0, 0);
    do_op("shl_31",   OP_SHL, 32'h1,         32'h1F,        32'h8000_0000, 0, 0, 0, 1, 0, 0, 0);
    do_op("shl_0",    OP_SHL, 32'h1234,      32'h20,        32'h1234,      0, 0, 0, 1, 0, 0, 0);
    do_op("shr_4",    OP_SHR, 32'h8000_0000, 32'h4,         32'h0800_0000, 0, 0, 0, 1, 0, 0, 0);

    // res_ready while idle must not disturb anything
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("idle_res_ready", 64'(bus.res_valid), 64'd0);

    do_op("mul_big",  OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0,         0, 1, 0, 33, 5, 0, 0);
    do_op("mul_3_5",  OP_MUL, 32'h3,         32'h5,         32'hF,         0, 0, 0, 33, 0, 0, 0);
    do_op("illegal",  4'b0011, 32'h5,        32'h7,         32'h0,         0, 0, 1, 1, 0, 0, 0);
    do_op("add_clr",  OP_ADD, 32'h1,         32'h2,         32'h3,         0, 0, 0, 1, 0, 0, 0);
    do_op("mul_stall", OP_MUL, 32'h1234_5678, 32'h10,       32'h2345_6780, 0, 1, 0, 43, 0, 10, 10);

    // Reset in the middle of a multiply discards it.
    bus.opcode = OP_MUL;
    bus.a = 32'h7;
    bus.b = 32'h9;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midmul_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_midmul_out", 64'(bus.out), 64'd0);
    chk("rst_midmul_busy", 64'(bus.busy), 64'd0);
    chk("rst_midmul_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_midmul_flags", 64'({bus.cout, bus.overflow, bus.illegal}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) seen++;
    end
    chk("no_valid_after_rst", 64'(seen), 64'd0);
    $display("txn reset_midmul res_valid_pulses=%0d", seen);

    do_op("add_post", OP_ADD, 32'h10,        32'h20,        32'h30,        0, 0, 0, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
